// File: rtl/am2910_seq.sv
// -----------------------------------------------------------------------------
// am2910_seq
//
// Microprogram sequencer equivalent to the Am2910. Every cycle it chooses the
// next control-store address Y from the direct input D, the microprogram
// counter uPC, the register/counter R or the top of a small subroutine/loop
// stack. It also updates uPC, R and the stack on the rising clock edge.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   nRST   : asynchronous active-low reset
//   I      : 4-bit sequencer instruction
//   D      : direct branch address / counter load value
//   nCC    : condition code, low means condition true
//   nCCEN  : condition enable, high forces the test to pass
//   CI     : incrementer carry-in (1 advances uPC, 0 repeats)
//   nRLD   : active-low unconditional load of R from D
//   Y      : next microinstruction address (combinational)
//   nFULL  : low while the stack holds DEPTH entries
//   nPL    : low selects the pipeline-register D source
//   nMAP   : low selects the mapping-ROM D source
//   nVECT  : low selects the interrupt-vector D source
// -----------------------------------------------------------------------------
module am2910_seq #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic [3:0]       I,
   input  logic [WIDTH-1:0] D,
   input  logic             nCC,
   input  logic             nCCEN,
   input  logic             CI,
   input  logic             nRLD,
   output logic [WIDTH-1:0] Y,
   output logic             nFULL,
   output logic             nPL,
   output logic             nMAP,
   output logic             nVECT
);

   localparam int spWidth = $clog2(DEPTH + 1);
   localparam logic [spWidth-1:0] spFull = spWidth'(DEPTH);

   typedef enum logic [3:0] {
      opJz   = 4'd0,
      opCjs  = 4'd1,
      opJmap = 4'd2,
      opCjp  = 4'd3,
      opPush = 4'd4,
      opJsrp = 4'd5,
      opCjv  = 4'd6,
      opJrp  = 4'd7,
      opRfct = 4'd8,
      opRpct = 4'd9,
      opCrtn = 4'd10,
      opCjpp = 4'd11,
      opLdct = 4'd12,
      opLoop = 4'd13,
      opCont = 4'd14,
      opTwb  = 4'd15
   } InstrOp;

   typedef enum logic [1:0] {
      stackHold,
      stackPush,
      stackPop,
      stackClear
   } StackOp;

   logic [WIDTH-1:0]   upc;
   logic [WIDTH-1:0]   regR;
   logic [WIDTH-1:0]   stack [DEPTH];
   logic [spWidth-1:0] sp;
   logic [spWidth-1:0] pushIdx;
   logic [WIDTH-1:0]   tos;
   logic               pass;
   logic               rz;
   logic               loadR;
   logic               decR;
   StackOp             stackOp;
   InstrOp             op;

   assign op   = InstrOp'(I);
   assign pass = nCCEN | ~nCC;
   assign rz   = (regR == '0);

   // The stack pointer counts occupied entries, so the top lives one below
   // it. An empty stack must read as zero rather than whatever stale value
   // sits in entry 0 (entries survive JZ, which only clears the pointer).
   always_comb begin
      tos = '0;
      if (sp != '0) begin
         tos = stack[sp - 1'b1];
      end
   end

   // A push into a full stack does not grow it; it replaces the top entry.
   assign pushIdx = (sp == spFull) ? (spFull - 1'b1) : sp;

   // Instruction decode: picks the address source and the side effects on the
   // stack and on R. Each instruction requests at most one stack operation, so
   // a push and a pop can never coincide. The decrement request is only raised
   // while R is non-zero, so R never wraps from zero to all-ones.
   always_comb begin
      Y       = upc;
      stackOp = stackHold;
      loadR   = 1'b0;
      decR    = 1'b0;
      case (op)
         opJz: begin
            Y       = '0;
            stackOp = stackClear;
         end
         opCjs: begin
            if (pass) begin
               Y       = D;
               stackOp = stackPush;
            end
         end
         opJmap: begin
            Y = D;
         end
         opCjp, opCjv: begin
            if (pass) begin
               Y = D;
            end
         end
         opPush: begin
            stackOp = stackPush;
            loadR   = pass;
         end
         opJsrp: begin
            Y       = pass ? D : regR;
            stackOp = stackPush;
         end
         opJrp: begin
            Y = pass ? D : regR;
         end
         opRfct: begin
            if (!rz) begin
               Y    = tos;
               decR = 1'b1;
            end else begin
               stackOp = stackPop;
            end
         end
         opRpct: begin
            if (!rz) begin
               Y    = D;
               decR = 1'b1;
            end
         end
         opCrtn: begin
            if (pass) begin
               Y       = tos;
               stackOp = stackPop;
            end
         end
         opCjpp: begin
            if (pass) begin
               Y       = D;
               stackOp = stackPop;
            end
         end
         opLdct: begin
            loadR = 1'b1;
         end
         opLoop: begin
            if (pass) begin
               stackOp = stackPop;
            end else begin
               Y = tos;
            end
         end
         opCont: begin
            Y = upc;
         end
         opTwb: begin
            if (pass) begin
               stackOp = stackPop;
               decR    = !rz;
            end else if (!rz) begin
               Y    = tos;
               decR = 1'b1;
            end else begin
               Y       = D;
               stackOp = stackPop;
            end
         end
         default: begin
            Y = upc;
         end
      endcase
   end

   // Exactly one D-source enable is low: mapping ROM for JMAP, interrupt
   // vector for CJV, pipeline register for everything else.
   assign nMAP  = (op != opJmap);
   assign nVECT = (op != opCjv);
   assign nPL   = (op == opJmap) || (op == opCjv);

   assign nFULL = (sp != spFull);

   // The microprogram counter always captures the chosen address plus the
   // carry-in, which lets CI = 0 repeat the same microinstruction.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         upc <= '0;
      end else begin
         upc <= Y + {{(WIDTH-1){1'b0}}, CI};
      end
   end

   // The external load has priority over both instruction-driven loads and
   // decrements, so a counting instruction issued with nRLD low just reloads.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         regR <= '0;
      end else if (!nRLD || loadR) begin
         regR <= D;
      end else if (decR && !rz) begin
         regR <= regR - 1'b1;
      end
   end

   // The stack saves the pre-edge uPC on a push. The pointer saturates at both
   // ends: pushes at full overwrite the top, pops at empty do nothing.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         sp <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            stack[k] <= '0;
         end
      end else begin
         case (stackOp)
            stackPush: begin
               stack[pushIdx] <= upc;
               if (sp != spFull) begin
                  sp <= sp + 1'b1;
               end
            end
            stackPop: begin
               if (sp != '0) begin
                  sp <= sp - 1'b1;
               end
            end
            stackClear: begin
               sp <= '0;
            end
            default: begin
               sp <= sp;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_am2910_seq.sv
// -----------------------------------------------------------------------------
// tb_am2910_seq
//
// Self-checking bench for the am2910_seq microprogram sequencer. Directed
// scenarios check the documented behaviour with constant expectations, and a
// randomized run compares every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_am2910_seq;

   localparam int WIDTH = 12;
   localparam int DEPTH = 5;

   localparam logic [3:0] opJz   = 4'd0;
   localparam logic [3:0] opCjs  = 4'd1;
   localparam logic [3:0] opJmap = 4'd2;
   localparam logic [3:0] opCjp  = 4'd3;
   localparam logic [3:0] opPush = 4'd4;
   localparam logic [3:0] opJsrp = 4'd5;
   localparam logic [3:0] opCjv  = 4'd6;
   localparam logic [3:0] opJrp  = 4'd7;
   localparam logic [3:0] opRfct = 4'd8;
   localparam logic [3:0] opRpct = 4'd9;
   localparam logic [3:0] opCrtn = 4'd10;
   localparam logic [3:0] opCjpp = 4'd11;
   localparam logic [3:0] opLdct = 4'd12;
   localparam logic [3:0] opLoop = 4'd13;
   localparam logic [3:0] opCont = 4'd14;
   localparam logic [3:0] opTwb  = 4'd15;

   logic             clk;
   logic             nRST;
   logic [3:0]       I;
   logic [WIDTH-1:0] D;
   logic             nCC;
   logic             nCCEN;
   logic             CI;
   logic             nRLD;
   logic [WIDTH-1:0] Y;
   logic             nFULL;
   logic             nPL;
   logic             nMAP;
   logic             nVECT;

   int checks = 0;
   int errors = 0;

   // Reference model state: the stack is a queue whose back is the top.
   logic [WIDTH-1:0] upcM;
   logic [WIDTH-1:0] rM;
   logic [WIDTH-1:0] stackQ[$];

   // Predictions for the current cycle, filled in by modelEval.
   logic [WIDTH-1:0] expY;
   logic [2:0]       expSrc;
   logic             expNfull;
   int               expStack;
   int               expROp;

   am2910_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .nRST  (nRST),
      .I     (I),
      .D     (D),
      .nCC   (nCC),
      .nCCEN (nCCEN),
      .CI    (CI),
      .nRLD  (nRLD),
      .Y     (Y),
      .nFULL (nFULL),
      .nPL   (nPL),
      .nMAP  (nMAP),
      .nVECT (nVECT)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected to finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void modelReset();
      upcM = '0;
      rM   = '0;
      stackQ.delete();
   endfunction

   // Stack codes: 0 none, 1 push, 2 pop, 3 clear. R codes: 0 none, 1 load, 2 dec.
   function automatic void modelEval();
      logic             pass;
      logic             rz;
      logic [WIDTH-1:0] top;
      pass     = nCCEN | ~nCC;
      rz       = (rM == 0);
      top      = (stackQ.size() == 0) ? '0 : stackQ[$];
      expY     = upcM;
      expStack = 0;
      expROp   = 0;
      case (I)
         opJz:   begin expY = '0; expStack = 3; end
         opCjs:  if (pass) begin expY = D; expStack = 1; end
         opJmap: expY = D;
         opCjp:  if (pass) expY = D;
         opPush: begin expStack = 1; if (pass) expROp = 1; end
         opJsrp: begin expY = pass ? D : rM; expStack = 1; end
         opCjv:  if (pass) expY = D;
         opJrp:  expY = pass ? D : rM;
         opRfct: if (!rz) begin expY = top; expROp = 2; end else expStack = 2;
         opRpct: if (!rz) begin expY = D; expROp = 2; end
         opCrtn: if (pass) begin expY = top; expStack = 2; end
         opCjpp: if (pass) begin expY = D; expStack = 2; end
         opLdct: expROp = 1;
         opLoop: if (pass) expStack = 2; else expY = top;
         opCont: expY = upcM;
         default: begin
            if (pass) begin
               expStack = 2;
               expROp   = 2;
            end else if (!rz) begin
               expY   = top;
               expROp = 2;
            end else begin
               expY     = D;
               expStack = 2;
            end
         end
      endcase
      expSrc   = (I == opJmap) ? 3'b101 : (I == opCjv) ? 3'b110 : 3'b011;
      expNfull = (stackQ.size() == DEPTH) ? 1'b0 : 1'b1;
   endfunction

   function automatic void modelAdvance();
      if (expStack == 1) begin
         if (stackQ.size() == DEPTH) stackQ[DEPTH-1] = upcM;
         else stackQ.push_back(upcM);
      end else if (expStack == 2) begin
         if (stackQ.size() > 0) void'(stackQ.pop_back());
      end else if (expStack == 3) begin
         stackQ.delete();
      end
      if (!nRLD || expROp == 1) rM = D;
      else if (expROp == 2 && rM != 0) rM = rM - 1'b1;
      upcM = expY + WIDTH'(CI);
   endfunction

   // Drive one cycle's inputs and let the combinational outputs settle.
   task automatic applyStimulus(input logic [3:0] i, input logic [WIDTH-1:0] d,
                                input logic ncc, input logic nccen,
                                input logic ci, input logic nrld);
      I     = i;
      D     = d;
      nCC   = ncc;
      nCCEN = nccen;
      CI    = ci;
      nRLD  = nrld;
      #1;
      modelEval();
   endtask

   task automatic tick();
      @(posedge clk);
      modelAdvance();
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      applyStimulus(opCont, '0, 1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      checks++;
      if (Y !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_y: Y=%h expected 000", Y);
      end
      checks++;
      if (nFULL !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_nfull: nFULL=%b expected 1", nFULL);
      end
      checks++;
      if ({nPL, nMAP, nVECT} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL reset_src: {nPL,nMAP,nVECT}=%b expected 011", {nPL, nMAP, nVECT});
      end
      modelReset();
      @(negedge clk);
      nRST = 1'b1;
   endtask

   task automatic test_cont();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(opCont, '0, 1'b1, 1'b1, 1'b1, 1'b1);
         checks++;
         if (Y !== 12'(k)) begin
            errors++;
            $display("[TB] FAIL cont_count: Y=%h expected %h", Y, 12'(k));
         end
         tick();
      end
      nRST = 1'b0;
      #1;
      checks++;
      if (Y !== 12'h000) begin
         errors++;
         $display("[TB] FAIL midreset_y: Y=%h expected 000", Y);
      end
      modelReset();
      @(negedge clk);
      nRST = 1'b1;
   endtask

   task automatic test_subroutine();
      applyStimulus(opCjp, 12'h010, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      applyStimulus(opCjs, 12'h123, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h123) begin
         errors++;
         $display("[TB] FAIL cjs_target: Y=%h expected 123", Y);
      end
      tick();
      applyStimulus(opCont, '0, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h124) begin
         errors++;
         $display("[TB] FAIL sub_cont: Y=%h expected 124", Y);
      end
      tick();
      applyStimulus(opCrtn, '0, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h010) begin
         errors++;
         $display("[TB] FAIL crtn_return: Y=%h expected 010", Y);
      end
      tick();
      applyStimulus(opCrtn, '0, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h000) begin
         errors++;
         $display("[TB] FAIL crtn_empty: Y=%h expected 000", Y);
      end
      tick();
   endtask

   task automatic test_loop();
      applyStimulus(opLdct, 12'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(opRpct, 12'h200, 1'b1, 1'b1, 1'b1, 1'b1);
         checks++;
         if (Y !== 12'h200 || nPL !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rpct_loop: Y=%h nPL=%b expected 200 / 0", Y, nPL);
         end
         tick();
      end
      applyStimulus(opRpct, 12'h200, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h201 || nPL !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rpct_exit: Y=%h nPL=%b expected 201 / 0", Y, nPL);
      end
      tick();
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] popExp [5];
      popExp = '{12'd6, 12'd4, 12'd3, 12'd2, 12'd1};
      applyStimulus(opJz, '0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(opPush, '0, 1'b1, 1'b1, 1'b1, 1'b1);
         checks++;
         if (Y !== 12'(k) || nFULL !== ((k == 6) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("[TB] FAIL push_fill: Y=%h nFULL=%b expected %h / %b", Y, nFULL, 12'(k), (k == 6) ? 1'b0 : 1'b1);
         end
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         applyStimulus(opCrtn, '0, 1'b1, 1'b1, 1'b1, 1'b1);
         checks++;
         if (Y !== popExp[k]) begin
            errors++;
            $display("[TB] FAIL crtn_unwind: Y=%h expected %h", Y, popExp[k]);
         end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(opCrtn, '0, 1'b1, 1'b1, 1'b1, 1'b1);
         checks++;
         if (Y !== 12'h000 || nFULL !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pop_empty: Y=%h nFULL=%b expected 000 / 1", Y, nFULL);
         end
         tick();
      end
   endtask

   task automatic test_condition();
      applyStimulus(opCjp, 12'h0AA, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h0AA) begin
         errors++;
         $display("[TB] FAIL ccen_disabled: Y=%h expected 0AA", Y);
      end
      tick();
      applyStimulus(opCjp, 12'h0AA, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h0AB) begin
         errors++;
         $display("[TB] FAIL ccen_enabled: Y=%h expected 0AB", Y);
      end
      tick();
      applyStimulus(opJmap, 12'h345, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h345 || {nPL, nMAP, nVECT} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL jmap_src: Y=%h src=%b expected 345 / 101", Y, {nPL, nMAP, nVECT});
      end
      tick();
      applyStimulus(opCjv, 12'h0F0, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (Y !== 12'h0F0 || {nPL, nMAP, nVECT} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL cjv_src: Y=%h src=%b expected 0F0 / 110", Y, {nPL, nMAP, nVECT});
      end
      tick();
   endtask

   task automatic test_twb();
      for (int run = 0; run < 2; run++) begin
         applyStimulus(opJz, '0, 1'b1, 1'b1, 1'b1, 1'b1);
         tick();
         applyStimulus(opCjp, 12'h050, 1'b1, 1'b1, 1'b0, 1'b1);
         tick();
         applyStimulus(opPush, 12'd2, 1'b1, 1'b1, 1'b1, 1'b1);
         tick();
         if (run == 0) begin
            for (int k = 0; k < 2; k++) begin
               applyStimulus(opTwb, 12'h300, 1'b1, 1'b0, 1'b1, 1'b1);
               checks++;
               if (Y !== 12'h050) begin
                  errors++;
                  $display("[TB] FAIL twb_count: Y=%h expected 050", Y);
               end
               tick();
            end
            applyStimulus(opTwb, 12'h300, 1'b1, 1'b0, 1'b1, 1'b1);
            checks++;
            if (Y !== 12'h300) begin
               errors++;
               $display("[TB] FAIL twb_exit: Y=%h expected 300", Y);
            end
            tick();
            applyStimulus(opCrtn, '0, 1'b1, 1'b1, 1'b1, 1'b1);
            checks++;
            if (Y !== 12'h000) begin
               errors++;
               $display("[TB] FAIL twb_popped: Y=%h expected 000", Y);
            end
            tick();
         end else begin
            applyStimulus(opTwb, 12'd7, 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (Y !== 12'h050) begin
               errors++;
               $display("[TB] FAIL twb_rld_y: Y=%h expected 050", Y);
            end
            tick();
            applyStimulus(opJrp, '0, 1'b1, 1'b0, 1'b1, 1'b1);
            checks++;
            if (Y !== 12'h007) begin
               errors++;
               $display("[TB] FAIL twb_rld_r: Y=%h expected 007", Y);
            end
            tick();
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            nRST = 1'b0;
            #1;
            modelReset();
            modelEval();
            checks++;
            if (Y !== expY || nFULL !== 1'b1) begin
               errors++;
               $display("[TB] FAIL rand_reset: Y=%h nFULL=%b expected %h / 1", Y, nFULL, expY);
            end
            @(negedge clk);
            nRST = 1'b1;
         end
         applyStimulus(4'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15) == 0 ? 0 : $urandom),
                       1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0),
                       1'($urandom_range(0, 9) != 0));
         checks++;
         if (Y !== expY) begin
            errors++;
            $display("[TB] FAIL rand_y: I=%0d Y=%h expected %h", I, Y, expY);
         end
         checks++;
         if ({nPL, nMAP, nVECT} !== expSrc || nFULL !== expNfull) begin
            errors++;
            $display("[TB] FAIL rand_flags: I=%0d src=%b nFULL=%b expected %b / %b", I, {nPL, nMAP, nVECT}, nFULL, expSrc, expNfull);
         end
         tick();
      end
   endtask

   initial begin
      nRST  = 1'b0;
      I     = opCont;
      D     = '0;
      nCC   = 1'b1;
      nCCEN = 1'b1;
      CI    = 1'b1;
      nRLD  = 1'b1;
      modelReset();
      test_reset();
      test_cont();
      test_subroutine();
      test_loop();
      test_overflow();
      test_condition();
      test_twb();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
